// File: rtl/irq_pending_latch_v_pkg.sv
// rtl/irq_pending_latch_v_pkg.sv - shared widths for the request latch and its priority encoder
package irq_pending_latch_v_pkg;

  // The encoder uses the same defaults, so both ends of i_code always agree.
  localparam int N_REQ_DEF  = 8;
  localparam int CODE_W_DEF = 3;

endpackage

// File: rtl/irq_pending_latch_v_sync_edge_det.sv
// rtl/irq_pending_latch_v_sync_edge_det.sv - 3-flop synchronizer with rising-edge pulse for one request line
module sync_edge_det_v (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  output logic o_edge
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_req;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 resets low, so a line held high through reset still yields one event.
  assign o_edge = s2_q & ~s3_q;

endmodule

// File: rtl/irq_pending_latch_v.sv
// rtl/irq_pending_latch_v.sv - sticky pending/lost latch for asynchronous request lines
module irq_pending_latch_v
  import irq_pending_latch_v_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic [N_REQ-1:0]  i_mask,
  input  logic              i_ack,
  input  logic [CODE_W-1:0] i_ack_code,
  input  logic              i_clr_lost,
  output logic [N_REQ-1:0]  o_code,
  output logic              o_valid,
  output logic [N_REQ-1:0]  o_pending,
  output logic [N_REQ-1:0]  o_lost
);

  logic [N_REQ-1:0] edge_det;
  logic [N_REQ-1:0] ack_vec;
  logic [N_REQ-1:0] lost_set;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] lost_q, lost_d;

  for (genvar n = 0; n < N_REQ; n++) begin : g_sync
    sync_edge_det_v u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_req  (i_req[n]),
      .o_edge (edge_det[n])
    );
  end

  // Codes past the top bit shift out of the vector and so acknowledge nothing.
  assign ack_vec = i_ack ? (N_REQ'(1) << i_ack_code) : '0;

  always_comb begin
    lost_set  = edge_det & pending_q & ~ack_vec;
    pending_d = edge_det | (pending_q & ~ack_vec);
    lost_d    = (i_clr_lost ? '0 : lost_q) | lost_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      lost_q    <= '0;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  assign o_code    = pending_q & i_mask;
  assign o_valid   = |o_code;
  assign o_pending = pending_q;
  assign o_lost    = lost_q;

endmodule

// File: tb/tb_irq_pending_latch_v.sv
// tb/tb_irq_pending_latch_v.sv - directed bench for irq_pending_latch_v
module tb_irq_pending_latch_v;

  logic       i_clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       i_rst;
  logic [7:0] i_req;
  logic [7:0] i_mask;
  logic       i_ack;
  logic [2:0] i_ack_code;
  logic       i_clr_lost;
  logic [7:0] o_code;
  logic       o_valid;
  logic [7:0] o_pending;
  logic [7:0] o_lost;

  int checks = 0;
  int errors = 0;

  irq_pending_latch_v dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_mask     (i_mask),
    .i_ack      (i_ack),
    .i_ack_code (i_ack_code),
    .i_clr_lost (i_clr_lost),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .o_pending  (o_pending),
    .o_lost     (o_lost)
  );

  always #5 if (clk_en) i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [2:0] code);
    i_ack = 1'b1;
    i_ack_code = code;
    tick(1);
    i_ack = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_req = 8'hFF; i_mask = 8'hFF;
    i_ack = 1'b0; i_ack_code = 3'd0; i_clr_lost = 1'b0;
    #3;
    chk("rst_pending", o_pending, 8'h00);
    chk("rst_valid", {7'b0, o_valid}, 8'h00);
    chk("rst_lost", o_lost, 8'h00);
    chk("rst_code", o_code, 8'h00);

    i_req = 8'h00;
    clk_en = 1'b1;
    tick(2);
    i_rst = 1'b0;
    tick(1);

    // basic event on line 5: pending after the third edge
    i_req = 8'h20;
    tick(2);
    chk("basic_early", o_pending, 8'h00);
    tick(1);
    chk("basic_pending", o_pending, 8'h20);
    chk("basic_code", o_code, 8'h20);
    chk("basic_valid", {7'b0, o_valid}, 8'h01);
    ack(3'd5);
    chk("basic_ack", o_pending, 8'h00);
    chk("basic_ack_valid", {7'b0, o_valid}, 8'h00);
    i_req = 8'h00;
    tick(3);

    // several lines at once, serviced highest first
    i_req = 8'hC2;
    tick(3);
    chk("multi_code", o_code, 8'hC2);
    ack(3'd7);
    chk("multi_ack7", o_pending, 8'h42);
    ack(3'd6);
    chk("multi_ack6", o_pending, 8'h02);
    ack(3'd4);
    chk("multi_ack_idle", o_pending, 8'h02);
    ack(3'd1);
    chk("multi_ack1", o_pending, 8'h00);
    chk("multi_lost", o_lost, 8'h00);
    i_req = 8'h00;
    tick(3);

    // second event on line 2 before service is lost
    i_req = 8'h04;
    tick(4);
    i_req = 8'h00;
    tick(4);
    chk("ovf_first", o_pending, 8'h04);
    i_req = 8'h04;
    tick(2);
    chk("ovf_lost_early", o_lost, 8'h00);
    tick(1);
    chk("ovf_lost", o_lost, 8'h04);
    chk("ovf_pending", o_pending, 8'h04);
    i_clr_lost = 1'b1;
    tick(1);
    i_clr_lost = 1'b0;
    chk("clr_lost", o_lost, 8'h00);
    chk("clr_pending", o_pending, 8'h04);
    ack(3'd2);
    i_req = 8'h00;
    tick(4);

    // edge and ack of line 3 on the same edge
    i_req = 8'h08;
    tick(3);
    chk("coll_first", o_pending, 8'h08);
    i_req = 8'h00;
    tick(4);
    i_req = 8'h08;
    tick(2);
    ack(3'd3);
    chk("coll_pending", o_pending, 8'h08);
    chk("coll_lost", o_lost, 8'h00);
    ack(3'd3);
    chk("coll_cleared", o_pending, 8'h00);
    i_req = 8'h00;
    tick(4);

    // masked line still latches, unmask reveals it immediately
    i_mask = 8'h00;
    i_req = 8'h01;
    tick(3);
    chk("mask_pending", o_pending, 8'h01);
    chk("mask_code", o_code, 8'h00);
    chk("mask_valid", {7'b0, o_valid}, 8'h00);
    i_mask = 8'h01;
    #1;
    chk("unmask_code", o_code, 8'h01);
    chk("unmask_valid", {7'b0, o_valid}, 8'h01);

    // asynchronous reset mid-operation
    #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_pending", o_pending, 8'h00);
    chk("midrst_valid", {7'b0, o_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch_v.md
Name: irq_pending_latch_v

Overview:
- Upstream stage of priority_enc_8_3_v. Captures rising edges on 8 asynchronous request lines into sticky pending bits.
- Presents the masked pending vector as the encoder's i_code input. The encoder output, echoed back with an acknowledge, clears the serviced bit.
- Tracks requests lost because they arrived while the same bit was already pending.

Parameters:
- N_REQ, 8, number of request lines; must equal the encoder input width.
- CODE_W, 3, acknowledge code width; must equal clog2(N_REQ).

Ports:
- i_clk  in  1  single system clock; all state on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  raw asynchronous request lines; an event is a 0->1 transition.
- i_mask  in  N_REQ  1 = bit visible to encoder; synchronous to i_clk.
- i_ack  in  1  single-cycle pulse: service of i_ack_code complete.
- i_ack_code  in  CODE_W  index of the bit to clear; the encoder o_code value.
- i_clr_lost  in  1  pulse: clear all o_lost bits.
- o_code  out  N_REQ  pending & i_mask; drives encoder i_code.
- o_valid  out  1  OR-reduction of o_code.
- o_pending  out  N_REQ  raw pending register, unmasked.
- o_lost  out  N_REQ  sticky overflow flags.

Behaviour:
- Reset (asynchronous, on i_rst high): all synchronizer flops, pending and lost go to 0. Therefore o_code=0, o_valid=0, o_pending=0 and o_lost=0 immediately, independent of the clock.
- Per-line synchronizer: s1 <= i_req[n]; s2 <= s1; s3 <= s2.
- Edge detect: edge[n] = s2 & ~s3 (combinational).
- Latency: i_req[n] goes high and meets setup before edge 0. s2 is then 1 after edge 1, and pending[n]=1 after edge 2. o_code/o_valid follow combinationally within the same cycle.
- Minimum pulse width: i_req pulses shorter than one i_clk period may be missed. i_req must hold each level for at least 2 clock periods.
- Line held high through reset release: s3=0, so this counts as one event. pending sets 3 edges after release.
- Per-bit update each edge, in priority order:
  - edge[n]=1: pending[n] <= 1.
    - If pending[n] was already 1 and this cycle is not an ack of bit n, also set lost[n] <= 1.
  - else if i_ack=1 and i_ack_code==n: pending[n] <= 0.
  - else hold.
- Simultaneous edge and ack on the same bit: set wins, pending stays 1, lost is not set. The ack consumed the old event; the new one is queued.
- Ack of a bit whose pending is 0: no effect, no error.
- i_ack_code >= N_REQ (only possible when N_REQ is not a power of 2): ignored.
- Mask affects only o_code/o_valid. Masked bits still latch and still report lost. Unmasking reveals them the same cycle.
- i_clr_lost: lost <= 0 on that edge. A lost-set condition on the same edge wins for that bit.
- Independent bits: multiple edges in one cycle all latch. Only one bit can be acked per cycle.
- No counters wrap. All state is single-bit sticky.
- Reset asserted mid-operation discards all pending and lost state. Requests in flight in the synchronizer are discarded.

Decomposition:
- Shared include file holds N_REQ and CODE_W defaults. The encoder and this block both use it.
- Natural sub-module: sync_edge_det_v (3-flop synchronizer plus rising-edge output), instantiated N_REQ times via generate.
- Pending/lost update logic and masking stay in the top level.

Test Plan:
- Reset check: assert i_rst with i_req=8'hFF and no clock running -> o_pending=0, o_valid=0, o_lost=0 immediately.
- Basic event: i_mask=8'hFF, raise i_req[5] -> o_pending=8'h20 exactly 3 rising edges later and o_valid=1. Then i_ack=1, i_ack_code=3'd5 for one cycle -> o_pending=8'h00, o_valid=0 next edge.
- Multiple events with priority chain: raise i_req[1], i_req[6] and i_req[7] in the same cycle -> o_code=8'hC2. Feeding the encoder gives o_code 3'd7. Ack 7 -> 8'h42; ack 6 -> 8'h02; ack 1 -> 0.
- Overflow: pulse i_req[2] twice (4 cycles high, 4 low) with no ack -> o_pending[2]=1, o_lost=8'h04. Then i_clr_lost -> o_lost=0, pending still 8'h04.
- Edge/ack collision: arrange for edge[3] and an ack of code 3 in the same cycle -> o_pending[3] stays 1 and o_lost[3]=0.
- Mask behaviour: i_mask=8'h00, raise i_req[0] -> o_pending=8'h01, o_code=0, o_valid=0. Set i_mask=8'h01 -> o_code=8'h01, o_valid=1 the same cycle.
